// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer: waits for the delay slot, then holds a redirect to fetch.
// Optional performance counters are enabled by defining BRANCH_REDIRECT_PERF_EN.
module branch_redirect_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic              res_taken,
  input  logic              res_branch,
  input  logic              res_jmp,
  input  logic              res_jr,
  input  logic              ds_fetched,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              redirect_adel,
  output logic              flush_if,
  output logic              busy,
`ifdef BRANCH_REDIRECT_PERF_EN
  output logic [CNT_W-1:0]  cnt_taken,
  output logic [CNT_W-1:0]  cnt_not_taken,
  output logic [CNT_W-1:0]  cnt_jump,
`endif
  input  logic              late_flush
);

  typedef enum logic [1:0] {IDLE, WAIT_DS, REDIRECT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q;
  logic              jr_q;
  logic              accept;
  logic              is_jump;
  logic              is_taken_br;
  logic              is_nt_br;
  logic              latch_en;

  // A jump bit dominates the branch bits when classifying a result.
  always_comb begin
    accept      = res_valid && (state_q == IDLE) && !late_flush;
    is_jump     = res_jmp || res_jr;
    is_taken_br = res_branch && res_taken && !is_jump;
    is_nt_br    = res_branch && !res_taken && !is_jump;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    if (late_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && (is_jump || is_taken_br)) begin
            latch_en = 1'b1;
            state_d  = ds_fetched ? REDIRECT : WAIT_DS;
          end
        end
        WAIT_DS: begin
          if (ds_fetched) state_d = REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      jr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        tgt_q <= res_addr;
        jr_q  <= res_jr;
      end
    end
  end

  // Every output is a decode of registered state; redirect_ready only steers state_d.
  always_comb begin
    res_ready      = (state_q == IDLE);
    busy           = (state_q != IDLE);
    redirect_valid = (state_q == REDIRECT);
    flush_if       = (state_q == REDIRECT);
    redirect_pc    = tgt_q;
    redirect_adel  = (state_q == REDIRECT) && jr_q && (|tgt_q[1:0]);
  end

`ifdef BRANCH_REDIRECT_PERF_EN
  logic [CNT_W-1:0] cnt_taken_q, cnt_not_taken_q, cnt_jump_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_taken_q     <= '0;
      cnt_not_taken_q <= '0;
      cnt_jump_q      <= '0;
    end else if (accept) begin
      if (is_taken_br) cnt_taken_q     <= cnt_taken_q + CNT_W'(1);
      if (is_nt_br)    cnt_not_taken_q <= cnt_not_taken_q + CNT_W'(1);
      if (is_jump)     cnt_jump_q      <= cnt_jump_q + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_taken     = cnt_taken_q;
    cnt_not_taken = cnt_not_taken_q;
    cnt_jump      = cnt_jump_q;
  end
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences PC redirects produced by the decode-stage branch/jump resolution logic toward the fetch stage.
- Accepts one resolved control-transfer result at a time and waits until the architectural delay-slot instruction has been fetched.
- Then issues a held valid/ready redirect to the PC/fetch unit and kills wrong-path fetches until the redirect is accepted.
- A late-stage flush (exception/eret) cancels any pending redirect.

Parameters:
- ADDR_W, 32, width of PC/target addresses.
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- res_valid  in  1  decode presents a resolved branch/jump result this cycle.
- res_ready  out  1  controller can accept a result (state IDLE).
- res_addr  in  ADDR_W  target address from the resolution bus.
- res_taken  in  1  conditional branch taken.
- res_branch  in  1  result is a conditional branch.
- res_jmp  in  1  result is J/JAL.
- res_jr  in  1  result is JR/JALR.
- ds_fetched  in  1  fetch hands the delay-slot instruction to decode this cycle.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  ADDR_W  latched target.
- redirect_adel  out  1  target[1:0] != 0; valid with redirect_valid.
- flush_if  out  1  kill instruction currently leaving fetch (wrong path).
- busy  out  1  state != IDLE.
- late_flush  in  1  synchronous cancel from later stage.

Behaviour:
- Reset: state=IDLE; target register=0; redirect_valid=0, flush_if=0, busy=0, redirect_adel=0, res_ready=1; counters=0.
- Accept condition: res_valid & res_ready.
  - Redirecting accept: res_jmp | res_jr | (res_branch & res_taken). Latch res_addr into tgt_q.
  - Not-taken branch (res_branch & !res_taken) is accepted with no state change.
  - Accept with no type bit set is ignored.
- States:
  - IDLE: on redirecting accept, go to REDIRECT if ds_fetched is high the same cycle, otherwise to WAIT_DS.
  - WAIT_DS: hold until ds_fetched, then go to REDIRECT. res_ready=0.
  - REDIRECT: redirect_valid=1, redirect_pc=tgt_q, flush_if=1. On redirect_ready, return to IDLE next cycle.
- Latency:
  - Accept at cycle N with ds_fetched=1 gives redirect_valid at N+1.
  - Handshake at cycle M gives res_ready=1 at M+1.
  - Zero-bubble back-to-back redirects are not supported.
- Handshake: redirect_valid, redirect_pc and redirect_adel stay stable until redirect_ready is sampled high. No retraction except via late_flush.
- flush_if:
  - Asserted only in REDIRECT.
  - Never asserted in WAIT_DS, because the delay slot must survive.
- late_flush: highest priority. From any state, go to IDLE next cycle. Drop redirect_valid/flush_if and ignore any same-cycle accept. redirect_ready in the same cycle is a don't-care; fetch gives the flush target priority.
- redirect_adel = |tgt_q[1:0] for the JR case; 0 otherwise. The redirect is still issued; the exception is raised downstream.
- All outputs are registered-state decodes. There are no combinational paths from redirect_ready to redirect_valid.
- Reset asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: BRANCH_REDIRECT_PERF_EN.
- When defined, adds three outputs:
  - cnt_taken (CNT_W): increments on each redirecting accept from a conditional branch.
  - cnt_not_taken (CNT_W): increments on each not-taken branch accept.
  - cnt_jump (CNT_W): increments on J/JR accepts.
- Counters wrap modulo 2^CNT_W and are not incremented on cycles with late_flush.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Taken BEQ, res_addr=0x00400100, ds_fetched=1 at the same cycle -> redirect_valid at N+1 with pc 0x00400100 and flush_if=1. Deassert one cycle after redirect_ready.
- JR with ds_fetched delayed 3 cycles -> busy for 3 cycles in WAIT_DS with flush_if=0 throughout, then redirect_valid.
- Not-taken BNE -> no redirect_valid; res_ready stays 1; cnt_not_taken=1 if the feature is enabled.
- redirect_ready held low 5 cycles -> redirect_valid/pc stable; res_valid during this time is not accepted (res_ready=0).
- late_flush asserted in WAIT_DS and in REDIRECT -> IDLE next cycle; no redirect issued; simultaneous res_valid ignored.
- JR target 0x00400102 -> redirect_adel=1 with redirect_valid. resetn pulsed low mid-REDIRECT -> all outputs 0 and res_ready=1 immediately.
